seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial pattern detector with a runtime-loadable pattern, selectable overlapping or non-overlapping matching, a thermometer progress output and a saturating match counter. It samples one bit per enabled clock from a serial stream and flags every occurrence of a PAT_W-bit pattern received MSB first. It sits on serial-input paths, for example frame-sync or header search ahead of a deserialiser, as a drop-in generalisation of the fixed 4-bit 1011 detector.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PAT_RST, 4'b1011: pattern loaded at reset, PAT_W bits, MSB is received first.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = history cleared after each match.
- CNT_W, 8: match counter width, ≥1.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_  in  1  asynchronous, active-high reset (asserting 1 resets immediately).
- en  in  1  sample-enable; d is consumed only when en=1.
- d  in  1  serial data bit.
- pat_ld  in  1  load pat_in as the new pattern.
- pat_in  in  PAT_W  pattern value for pat_ld.
- clr_cnt  in  1  synchronous clear of match_cnt and cnt_sat.
- detected  out  1  one-cycle pulse on a full match.
- completion  out  PAT_W  thermometer progress: bit i=1 iff ≥ i+1 pattern bits are currently matched.
- match_cnt  out  CNT_W  number of matches since reset or clr_cnt, saturating.
- cnt_sat  out  1  sticky flag: match_cnt has reached all-ones.

## Operation
- Internal state:
  - pat_r: current pattern, PAT_W bits.
  - hist: last PAT_W received bits; newest bit in LSB.
  - fill: count of valid history bits, 0..PAT_W, saturating at PAT_W.
- Enabled cycle (en=1, pat_ld=0):
  - hist' = {hist[PAT_W-2:0], d}.
  - fill' = min(fill+1, PAT_W).
  - L is the largest k in 0..fill' such that hist'[k-1:0] == pat_r[PAT_W-1:PAT_W-k]. This is the longest received suffix equal to a pattern prefix.
  - completion <= thermometer(L): low L bits set.
  - detected <= (L==PAT_W).
  - On a match, match_cnt increments unless it is already all-ones.
  - On a match with OVERLAP=0, fill <= 0. completion still shows all-ones for that cycle, and later matches use only bits received after it.
- Idle cycle (en=0, pat_ld=0): hist, fill and completion hold; detected <= 0; counter holds.
- pat_ld=1 takes priority over en:
  - pat_r <= pat_in; fill <= 0; completion <= 0; detected <= 0.
  - d is discarded that cycle.
  - match_cnt is unaffected.
- clr_cnt=1: match_cnt <= 0 and cnt_sat <= 0. If a match occurs in the same cycle, match_cnt <= 1 (the match counts after the clear).
- cnt_sat <= 1 when match_cnt becomes all-ones; it stays set until clr_cnt or reset.
- Reset values:
  - pat_r = PAT_RST.
  - hist = 0, fill = 0.
  - detected = 0, completion = 0, match_cnt = 0, cnt_sat = 0.

## Timing
- All outputs are registered.
- detected and completion update on the same edge that samples the completing bit, so they are visible one cycle after d is presented with en=1.
- detected is high for exactly one cycle per match. Back-to-back matches (OVERLAP=1, self-overlapping pattern) give consecutive pulses with no gap.
- match_cnt updates on the same edge as detected.
- A new pattern applies to the first enabled bit after the pat_ld edge.
- Reset mid-sequence discards all partial progress. The first enabled bit after release starts from fill=0.
- No combinational path from inputs to outputs.

## Test plan
- Default pattern 1011, OVERLAP=1, en=1, stream 1,0,1,1,0,1,1 -> completion 0001,0011,0111,1111,0011,0111,1111; detected pulses after bits 4 and 7; match_cnt=2.
- PAT_W=4, PAT_RST=1010, OVERLAP=0, stream 1,0,1,0,1,0,1,0 -> detected after bits 4 and 8 only; completion after bit 6 = 0011. Same stream with OVERLAP=1 -> detected after bits 4, 6 and 8.
- Default pattern, stream 1,0,1,1 with en=0 for 3 cycles between every bit -> single detect after the fourth enabled bit; detected=0 and completion held during every idle cycle.
- After 1,0,1, pulse pat_ld with pat_in=0110 while d=1 -> completion=0 next cycle; then 0,1,1,0 -> detected after the 4th bit; match_cnt unchanged by the load.
- CNT_W=2, default pattern, five 1011 matches -> match_cnt 1,2,3,3,3 and cnt_sat=1 from the third match. Then clr_cnt asserted in the same cycle as a match -> match_cnt=1, cnt_sat=0.
- Stream 1,0,1, then assert rst_ for 1 cycle asynchronously mid-clock -> all outputs 0 immediately. Then bits 1,1 -> completion 0001 then 0001, no detect.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Serial-detector bus: sample stream, pattern load and counter control going
// in, match pulse, progress and match counter coming back.
//
// Qualifier semantics: d is consumed on a rising clk edge only when en=1.
// pat_ld=1 overrides en, so d is dropped on a load edge. clr_cnt acts on its
// own edge. There is no back-pressure: the detector accepts every qualified
// bit, so there is no ready signal.
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             d;
    logic             pat_ld;
    logic [PAT_W-1:0] pat_in;
    logic             clr_cnt;
    logic             detected;
    logic [PAT_W-1:0] completion;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output en, d, pat_ld, pat_in, clr_cnt,
        input  detected, completion, match_cnt, cnt_sat
    );

    modport slave (
        input  en, d, pat_ld, pat_in, clr_cnt,
        output detected, completion, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector. The pattern is loadable at run time
// and is received MSB first. Matching can be overlapping or non-overlapping.
// Progress is reported as a thermometer code. Matches are counted in a
// saturating counter. All outputs are registered.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_,
    seq_detector_param_if.slave  bus
);
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] pat_r;
    logic [PAT_W-1:0] hist;
    logic [FW-1:0]    fill;
    logic             det_r;
    logic [PAT_W-1:0] comp_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;

    logic [PAT_W-1:0] hist_next;
    logic [FW-1:0]    fill_next;
    logic [PAT_W-1:0] therm;
    logic             match;
    logic             hit;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;
    int               best;

    // Longest valid history suffix that equals a pattern prefix, for the bit
    // being sampled now.
    always_comb begin
        hist_next = {hist[PAT_W-2:0], bus.d};
        fill_next = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
        best      = 0;
        for (int k = 1; k <= PAT_W; k++) begin
            if ((int'(fill_next) >= k) &&
                (((hist_next ^ (pat_r >> (PAT_W - k))) &
                  ({PAT_W{1'b1}} >> (PAT_W - k))) == '0)) begin
                best = k;
            end
        end
        therm = {PAT_W{1'b1}} >> (PAT_W - best);
        match = (best == PAT_W);
    end

    // Next match count. A clear in the same cycle as a match leaves a count
    // of one, because that match is counted after the clear.
    always_comb begin
        hit = bus.en & ~bus.pat_ld & match;
        if (bus.clr_cnt) begin
            cnt_next = hit ? CNT_W'(1) : '0;
            sat_next = &cnt_next;
        end else begin
            cnt_next = match_cnt_inc(cnt_r, hit);
            sat_next = sat_r | (&cnt_next);
        end
    end

    function automatic logic [CNT_W-1:0] match_cnt_inc(input logic [CNT_W-1:0] c,
                                                       input logic inc);
        if (inc && !(&c)) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    // Pattern, history and output registers. A load wins over en and drops d.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            pat_r  <= PAT_RST;
            hist   <= '0;
            fill   <= '0;
            det_r  <= 1'b0;
            comp_r <= '0;
            cnt_r  <= '0;
            sat_r  <= 1'b0;
        end else begin
            det_r <= 1'b0;
            if (bus.pat_ld) begin
                pat_r  <= bus.pat_in;
                fill   <= '0;
                comp_r <= '0;
            end else if (bus.en) begin
                hist   <= hist_next;
                // Without overlap, bits received up to the match are forgotten.
                fill   <= (match && (OVERLAP == 0)) ? '0 : fill_next;
                comp_r <= therm;
                det_r  <= match;
            end
            cnt_r <= cnt_next;
            sat_r <= sat_next;
        end
    end

    assign bus.detected   = det_r;
    assign bus.completion = comp_r;
    assign bus.match_cnt  = cnt_r;
    assign bus.cnt_sat    = sat_r;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Five differently configured instances share
// one input stream. Each instance is compared every cycle against a
// bit-history reference model. Directed cases with fixed expected values
// come first, then a randomised run.
module tb_seq_detector_param;
    localparam int N = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ = 1'b1;
    always #5 clk = ~clk;

    logic        en = 1'b0;
    logic        d = 1'b0;
    logic        pat_ld = 1'b0;
    logic [15:0] pat_in = '0;
    logic        clr_cnt = 1'b0;

    int checks = 0;
    int failures = 0;

    // ---------------- DUT instances ----------------
    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if0 ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if1 ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) if2 ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if3 ();
    seq_detector_param_if #(.PAT_W(6), .CNT_W(3)) if4 ();

    seq_detector_param u0 (.clk(clk), .rst_(rst_), .bus(if0));
    seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1010), .OVERLAP(0), .CNT_W(8))
        u1 (.clk(clk), .rst_(rst_), .bus(if1));
    seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1), .CNT_W(2))
        u2 (.clk(clk), .rst_(rst_), .bus(if2));
    seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1010), .OVERLAP(1), .CNT_W(8))
        u3 (.clk(clk), .rst_(rst_), .bus(if3));
    seq_detector_param #(.PAT_W(6), .PAT_RST(6'b110110), .OVERLAP(0), .CNT_W(3))
        u4 (.clk(clk), .rst_(rst_), .bus(if4));

    assign if0.en = en; assign if0.d = d; assign if0.pat_ld = pat_ld;
    assign if0.pat_in = pat_in[3:0]; assign if0.clr_cnt = clr_cnt;
    assign if1.en = en; assign if1.d = d; assign if1.pat_ld = pat_ld;
    assign if1.pat_in = pat_in[3:0]; assign if1.clr_cnt = clr_cnt;
    assign if2.en = en; assign if2.d = d; assign if2.pat_ld = pat_ld;
    assign if2.pat_in = pat_in[3:0]; assign if2.clr_cnt = clr_cnt;
    assign if3.en = en; assign if3.d = d; assign if3.pat_ld = pat_ld;
    assign if3.pat_in = pat_in[3:0]; assign if3.clr_cnt = clr_cnt;
    assign if4.en = en; assign if4.d = d; assign if4.pat_ld = pat_ld;
    assign if4.pat_in = pat_in[5:0]; assign if4.clr_cnt = clr_cnt;

    logic [31:0] o_det[N];
    logic [31:0] o_comp[N];
    logic [31:0] o_cnt[N];
    logic [31:0] o_sat[N];
    assign o_det[0] = 32'(if0.detected); assign o_comp[0] = 32'(if0.completion);
    assign o_cnt[0] = 32'(if0.match_cnt); assign o_sat[0] = 32'(if0.cnt_sat);
    assign o_det[1] = 32'(if1.detected); assign o_comp[1] = 32'(if1.completion);
    assign o_cnt[1] = 32'(if1.match_cnt); assign o_sat[1] = 32'(if1.cnt_sat);
    assign o_det[2] = 32'(if2.detected); assign o_comp[2] = 32'(if2.completion);
    assign o_cnt[2] = 32'(if2.match_cnt); assign o_sat[2] = 32'(if2.cnt_sat);
    assign o_det[3] = 32'(if3.detected); assign o_comp[3] = 32'(if3.completion);
    assign o_cnt[3] = 32'(if3.match_cnt); assign o_sat[3] = 32'(if3.cnt_sat);
    assign o_det[4] = 32'(if4.detected); assign o_comp[4] = 32'(if4.completion);
    assign o_cnt[4] = 32'(if4.match_cnt); assign o_sat[4] = 32'(if4.cnt_sat);

    // ---------------- reference model ----------------
    // Per instance: configuration, then the received bits since the last
    // reset, load or non-overlapping match (value + count), then expected outputs.
    int m_w[N]     = '{4, 4, 4, 4, 6};
    int m_rstp[N]  = '{11, 10, 11, 10, 54};
    int m_ov[N]    = '{1, 0, 1, 1, 0};
    int m_cntw[N]  = '{8, 8, 2, 8, 3};
    int m_pat[N];
    int m_bits[N];
    int m_nbits[N];
    int m_det[N];
    int m_comp[N];
    int m_cnt[N];
    int m_sat[N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pat[i] = m_rstp[i];
            m_bits[i] = 0;
            m_nbits[i] = 0;
            m_det[i] = 0;
            m_comp[i] = 0;
            m_cnt[i] = 0;
            m_sat[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int w;
            int maxc;
            int len;
            int hit;
            w = m_w[i];
            maxc = (1 << m_cntw[i]) - 1;
            hit = 0;
            if (pat_ld) begin
                m_pat[i] = int'(pat_in) % (1 << w);
                m_nbits[i] = 0;
                m_comp[i] = 0;
                m_det[i] = 0;
            end else if (en) begin
                m_bits[i] = (m_bits[i] * 2 + int'(d)) % (1 << w);
                if (m_nbits[i] < w) m_nbits[i]++;
                len = 0;
                for (int k = 1; k <= m_nbits[i]; k++) begin
                    if ((m_bits[i] % (1 << k)) == (m_pat[i] / (1 << (w - k)))) len = k;
                end
                m_comp[i] = (1 << len) - 1;
                m_det[i] = (len == w) ? 1 : 0;
                hit = m_det[i];
                if (hit != 0 && m_ov[i] == 0) m_nbits[i] = 0;
            end else begin
                m_det[i] = 0;
            end
            if (clr_cnt) begin
                m_cnt[i] = hit;
                m_sat[i] = (m_cnt[i] == maxc) ? 1 : 0;
            end else begin
                if (hit != 0 && m_cnt[i] < maxc) m_cnt[i]++;
                if (m_cnt[i] == maxc) m_sat[i] = 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d_detected", i), o_det[i], 32'(m_det[i]));
            check($sformatf("u%0d_completion", i), o_comp[i], 32'(m_comp[i]));
            check($sformatf("u%0d_match_cnt", i), o_cnt[i], 32'(m_cnt[i]));
            check($sformatf("u%0d_cnt_sat", i), o_sat[i], 32'(m_sat[i]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drive, let the rising edge sample, update the
    // model, check at the next falling edge.
    task automatic tick(input bit e, input bit dd, input bit ld, input logic [15:0] pi,
                        input bit clr);
        en = e; d = dd; pat_ld = ld; pat_in = pi; clr_cnt = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic bit_in(input bit dd);
        tick(1'b1, dd, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        en = 1'b0; d = 1'b0; pat_ld = 1'b0; pat_in = '0; clr_cnt = 1'b0;
        rst_ = 1'b1;
        model_reset();
        @(negedge clk);
        rst_ = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p1_bits[7] = '{1, 0, 1, 1, 0, 1, 1};
        int p1_comp[7] = '{1, 3, 7, 15, 3, 7, 15};
        int p1_det[7]  = '{0, 0, 0, 1, 0, 0, 1};

        do_reset();
        check_all();

        // Default pattern, overlapping stream.
        for (int i = 0; i < 7; i++) begin
            bit_in(p1_bits[i][0]);
            check("p1_completion", o_comp[0], 32'(p1_comp[i]));
            check("p1_detected", o_det[0], 32'(p1_det[i]));
        end
        check("p1_match_cnt", o_cnt[0], 32'd2);

        // 1010 pattern, non-overlapping vs overlapping.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bit_in(((i % 2) == 0) ? 1'b1 : 1'b0);
            if (i == 5) check("p2_completion_nov", o_comp[1], 32'h3);
        end
        check("p2_cnt_nov", o_cnt[1], 32'd2);
        check("p2_cnt_ov", o_cnt[3], 32'd3);

        // Idle cycles between enabled bits.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bit_in((i == 1) ? 1'b0 : 1'b1);
            for (int j = 0; j < 3; j++) begin
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b0);
                check("p3_idle_detected", o_det[0], 32'd0);
            end
        end
        check("p3_match_cnt", o_cnt[0], 32'd1);

        // Pattern load in mid-stream.
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        tick(1'b1, 1'b1, 1'b1, 16'h0006, 1'b0);
        check("p4_completion_after_load", o_comp[0], 32'd0);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        check("p4_detected", o_det[0], 32'd1);
        check("p4_match_cnt", o_cnt[0], 32'd2);

        // Counter saturation and clear-with-match.
        do_reset();
        for (int m = 0; m < 5; m++) begin
            bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
            check("p5_sat_cnt", o_cnt[2], 32'((m < 3) ? m + 1 : 3));
        end
        check("p5_cnt_sat", o_sat[2], 32'd1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        check("p5_clr_cnt", o_cnt[2], 32'd1);
        check("p5_clr_sat", o_sat[2], 32'd0);

        // Asynchronous reset mid-cycle.
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        #2 rst_ = 1'b1;
        model_reset();
        #1;
        check_all();
        check("p6_async_completion", o_comp[0], 32'd0);
        @(negedge clk);
        rst_ = 1'b0;
        bit_in(1'b1);
        check("p6_completion_1", o_comp[0], 32'd1);
        bit_in(1'b1);
        check("p6_completion_2", o_comp[0], 32'd1);
        check("p6_detected", o_det[0], 32'd0);

        // Randomised run.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 750 == 749) begin
                do_reset();
            end else begin
                tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 39) == 0), 16'($urandom_range(0, 65535)),
                     1'($urandom_range(0, 59) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
